mem_controller: RTL and testbench
=================================

Name: mem_controller

Overview:
- Arbitrates load/store requests from many requesters onto a smaller number of external memory channels.
- Requesters are per-thread LSUs (data side) or per-core fetchers (program side).
- Sits between the cores inside gpu and the external memory_model instances; one instance for data memory, one (read-only) for program memory.
- Converts each requester's level valid/ready handshake into a channel transaction and relays the response back.

Parameters:
ADDR_WIDTH, 8, memory address width
DATA_WIDTH, 16, data word width (8 for the data instance, 16 for the program instance)
NUM_CONSUMERS, 8, requester count (NUM_CORES*THREADS_PER_BLOCK)
NUM_CHANNELS, 4, external memory channels; must be ≤ NUM_CONSUMERS
WRITE_ENABLE, 1, 0 gives a read-only controller: write ports ignored, mem writes tied low

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
consumer_read_valid  in  [NUM_CONSUMERS]  read request, held until its ready
consumer_read_addr  in  [NUM_CONSUMERS][ADDR_WIDTH]  read address
consumer_read_ready  out  [NUM_CONSUMERS]  read data valid, held until valid drops
consumer_read_data  out  [NUM_CONSUMERS][DATA_WIDTH]  read data
consumer_write_valid  in  [NUM_CONSUMERS]  write request
consumer_write_addr  in  [NUM_CONSUMERS][ADDR_WIDTH]  write address
consumer_write_data  in  [NUM_CONSUMERS][DATA_WIDTH]  write data
consumer_write_ready  out  [NUM_CONSUMERS]  write done, held until valid drops
mem_read_valid  out  [NUM_CHANNELS]  channel read request
mem_read_addr  out  [NUM_CHANNELS][ADDR_WIDTH]  channel read address
mem_read_ready  in  [NUM_CHANNELS]  memory read data valid
mem_read_data  in  [NUM_CHANNELS][DATA_WIDTH]  memory read data
mem_write_valid  out  [NUM_CHANNELS]  channel write request
mem_write_addr  out  [NUM_CHANNELS][ADDR_WIDTH]  channel write address
mem_write_data  out  [NUM_CHANNELS][DATA_WIDTH]  channel write data
mem_write_ready  in  [NUM_CHANNELS]  memory write accepted

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - Every channel goes to IDLE.
  - All claims are cleared.
  - Applies immediately, including mid-transaction. Any in-flight memory response is discarded after reset.
- Per-channel FSM: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING. All outputs are registered.
- Claiming:
  - A consumer is "pending" if its valid is high, it is unclaimed, and its ready is low.
  - Each cycle, IDLE channels are evaluated in ascending index. Each takes the lowest-index pending consumer not already taken by a lower channel this cycle.
  - A claimed consumer is never served by two channels.
- Read vs write: if a consumer asserts both, the read is served first. The write stays pending. A write is ignored entirely when WRITE_ENABLE=0.
- IDLE→READ_WAITING (edge N):
  - mem_read_valid=1 and mem_read_addr=consumer addr, visible after edge N.
  - Valid is held until mem_read_ready is sampled 1.
- READ_WAITING, mem_read_ready=1 at edge M:
  - Capture mem_read_data.
  - mem_read_valid=0.
  - consumer_read_ready=1 and consumer_read_data=captured value, visible after M.
  - Go to READ_RELAYING.
- READ_RELAYING: hold ready/data while consumer_read_valid=1. When valid is sampled 0: ready=0, claim released, back to IDLE. The channel can re-claim on the following edge.
- Writes use the same flow: WRITE_WAITING drives mem_write_valid/addr/data until mem_write_ready, then WRITE_RELAYING asserts consumer_write_ready.
- Controller overhead: 1 cycle request→mem valid, 1 cycle mem ready→consumer ready. Read round trip = memory latency + 2 cycles.
- A consumer dropping valid during WAITING is illegal. The channel completes the memory transaction, then releases in RELAYING on the first cycle valid is low.
- mem_*_ready while the channel is not WAITING is ignored.
- Addresses and data pass through unmodified. No width conversion.

Decomposition:
- Add mem_ctrl_state_t (5-state enum) to gpu_pkg.
- One sub-module: mem_channel_fsm, one instance per channel. It holds state, the claimed-consumer index ($clog2(NUM_CONSUMERS) bits) and registered outputs.
- Cross-channel claim arbitration and the consumer-side output muxing stay in mem_controller.

Test Plan:
1. One read: consumer 2, addr 0x05, mem[5]=0x03, latency 2 → mem_read_valid[0] after 1 cycle; consumer_read_ready[2]=1 with data 0x03 at 4 cycles; ready drops 1 cycle after valid drops.
2. Eight simultaneous reads, addrs 0..7 with mem[i]=i, 4 channels → consumers 0–3 served first on channels 0–3, consumers 4–7 after release; every consumer gets data i; never more than 4 mem_read_valid high.
3. Write: consumer 5 writes 0x07 to 0x15 → mem_write_valid with addr 0x15, data 0x07; after mem_write_ready, consumer_write_ready[5]=1; memory[0x15]=0x07.
4. Consumer 1 asserts read of 0x00 and write of 0x09 to 0x10 together → read completes first, then write; both readies are seen, in that order.
5. rst_n=0 while channel 0 is in READ_WAITING → all outputs 0 immediately; after release, a late mem_read_ready is ignored and no consumer_read_ready appears.
6. WRITE_ENABLE=0 with consumer_write_valid[0]=1 → mem_write_valid stays 0 and consumer_write_ready stays 0; concurrent reads are unaffected.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU types: memory-controller channel states and sizing helpers.
package gpu_pkg;

  typedef enum logic [2:0] {
    MC_IDLE,
    MC_READ_WAITING,
    MC_WRITE_WAITING,
    MC_READ_RELAYING,
    MC_WRITE_RELAYING
  } mem_ctrl_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// One external memory channel: carries a claimed consumer's request to
// memory and relays the response until the consumer drops its valid.
module mem_channel_fsm
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  grant_read,
  input  logic                  grant_write,
  input  logic [IDX_WIDTH-1:0]  grant_idx,
  input  logic [ADDR_WIDTH-1:0] grant_read_addr,
  input  logic [ADDR_WIDTH-1:0] grant_write_addr,
  input  logic [DATA_WIDTH-1:0] grant_write_data,
  input  logic                  req_read_valid,
  input  logic                  req_write_valid,
  input  logic                  mem_read_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_write_ready,
  output logic                  idle,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic                  mem_read_valid,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic                  mem_write_valid,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  read_ready,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  write_ready
);

  mem_ctrl_state_t state, state_n;
  logic [IDX_WIDTH-1:0]  idx_n;
  logic                  mrv_n, mwv_n, rr_n, wr_n;
  logic [ADDR_WIDTH-1:0] mra_n, mwa_n;
  logic [DATA_WIDTH-1:0] mwd_n, rd_n;

  assign idle = (state == MC_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= MC_IDLE;
      idx             <= '0;
      mem_read_valid  <= 1'b0;
      mem_read_addr   <= '0;
      mem_write_valid <= 1'b0;
      mem_write_addr  <= '0;
      mem_write_data  <= '0;
      read_ready      <= 1'b0;
      read_data       <= '0;
      write_ready     <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      mem_read_valid  <= mrv_n;
      mem_read_addr   <= mra_n;
      mem_write_valid <= mwv_n;
      mem_write_addr  <= mwa_n;
      mem_write_data  <= mwd_n;
      read_ready      <= rr_n;
      read_data       <= rd_n;
      write_ready     <= wr_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    mrv_n   = mem_read_valid;
    mra_n   = mem_read_addr;
    mwv_n   = mem_write_valid;
    mwa_n   = mem_write_addr;
    mwd_n   = mem_write_data;
    rr_n    = read_ready;
    rd_n    = read_data;
    wr_n    = write_ready;
    unique case (state)
      MC_IDLE: begin
        if (grant_read) begin
          state_n = MC_READ_WAITING;
          idx_n   = grant_idx;
          mrv_n   = 1'b1;
          mra_n   = grant_read_addr;
        end else if (grant_write) begin
          state_n = MC_WRITE_WAITING;
          idx_n   = grant_idx;
          mwv_n   = 1'b1;
          mwa_n   = grant_write_addr;
          mwd_n   = grant_write_data;
        end
      end
      MC_READ_WAITING: begin
        if (mem_read_ready) begin
          state_n = MC_READ_RELAYING;
          mrv_n   = 1'b0;
          rr_n    = 1'b1;
          rd_n    = mem_read_data;
        end
      end
      MC_WRITE_WAITING: begin
        if (mem_write_ready) begin
          state_n = MC_WRITE_RELAYING;
          mwv_n   = 1'b0;
          wr_n    = 1'b1;
        end
      end
      MC_READ_RELAYING: begin
        if (!req_read_valid) begin
          state_n = MC_IDLE;
          rr_n    = 1'b0;
        end
      end
      MC_WRITE_RELAYING: begin
        if (!req_write_valid) begin
          state_n = MC_IDLE;
          wr_n    = 1'b0;
        end
      end
      default: state_n = MC_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_controller.sv
// Arbitrates many consumer load/store handshakes onto a few memory
// channels; claim arbitration and consumer-side muxing live here.
module mem_controller
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter bit WRITE_ENABLE  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_read_addr,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_write_addr,
  input  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  mem_read_addr,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]  mem_write_addr,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

  localparam int IW = idx_width(NUM_CONSUMERS);

  logic [NUM_CHANNELS-1:0]                 ch_idle, ch_rr, ch_wr;
  logic [NUM_CHANNELS-1:0]                 g_rd, g_wr, req_rv, req_wv, ch_mwv;
  logic [NUM_CHANNELS-1:0][IW-1:0]         ch_idx, g_idx;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] g_raddr, g_waddr, ch_mwa;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] g_wdata, ch_rd, ch_mwd;
  logic [NUM_CONSUMERS-1:0]                claimed, rd_pend, wr_pend;
  logic [NUM_CONSUMERS-1:0]                taken, wr_req;
  logic                                    found;

  assign wr_req  = WRITE_ENABLE ? consumer_write_valid : '0;
  assign rd_pend = consumer_read_valid & ~consumer_read_ready & ~claimed;
  assign wr_pend = wr_req & ~consumer_write_ready & ~claimed;

  always_comb begin
    claimed = '0;
    req_rv  = '0;
    req_wv  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (!ch_idle[c]) claimed[ch_idx[c]] = 1'b1;
      req_rv[c] = consumer_read_valid[ch_idx[c]];
      req_wv[c] = wr_req[ch_idx[c]];
    end
  end

  // Lower channels pick first; a consumer taken this cycle is skipped.
  always_comb begin
    taken   = '0;
    found   = 1'b0;
    g_rd    = '0;
    g_wr    = '0;
    g_idx   = '0;
    g_raddr = '0;
    g_waddr = '0;
    g_wdata = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      if (ch_idle[c]) begin
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
          if (!found && !taken[i] && (rd_pend[i] || wr_pend[i])) begin
            found      = 1'b1;
            taken[i]   = 1'b1;
            g_idx[c]   = IW'(i);
            g_rd[c]    = rd_pend[i];
            g_wr[c]    = !rd_pend[i];
            g_raddr[c] = consumer_read_addr[i];
            g_waddr[c] = consumer_write_addr[i];
            g_wdata[c] = consumer_write_data[i];
          end
        end
      end
    end
  end

  always_comb begin
    consumer_read_ready  = '0;
    consumer_read_data   = '0;
    consumer_write_ready = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (ch_rr[c]) begin
        consumer_read_ready[ch_idx[c]] = 1'b1;
        consumer_read_data[ch_idx[c]]  = ch_rd[c];
      end
      if (ch_wr[c]) consumer_write_ready[ch_idx[c]] = 1'b1;
    end
  end

  assign mem_write_valid = WRITE_ENABLE ? ch_mwv : '0;
  assign mem_write_addr  = WRITE_ENABLE ? ch_mwa : '0;
  assign mem_write_data  = WRITE_ENABLE ? ch_mwd : '0;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    mem_channel_fsm #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH),
      .IDX_WIDTH (IW)
    ) u_fsm (
      .clk             (clk),
      .rst_n           (rst_n),
      .grant_read      (g_rd[c]),
      .grant_write     (g_wr[c]),
      .grant_idx       (g_idx[c]),
      .grant_read_addr (g_raddr[c]),
      .grant_write_addr(g_waddr[c]),
      .grant_write_data(g_wdata[c]),
      .req_read_valid  (req_rv[c]),
      .req_write_valid (req_wv[c]),
      .mem_read_ready  (mem_read_ready[c]),
      .mem_read_data   (mem_read_data[c]),
      .mem_write_ready (mem_write_ready[c]),
      .idle            (ch_idle[c]),
      .idx             (ch_idx[c]),
      .mem_read_valid  (mem_read_valid[c]),
      .mem_read_addr   (mem_read_addr[c]),
      .mem_write_valid (ch_mwv[c]),
      .mem_write_addr  (ch_mwa[c]),
      .mem_write_data  (ch_mwd[c]),
      .read_ready      (ch_rr[c]),
      .read_data       (ch_rd[c]),
      .write_ready     (ch_wr[c])
    );
  end

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: a read/write instance and a read-only instance
// driven against a behavioural memory with configurable latency.
module tb_mem_controller;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int NC  = 8;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][NC-1:0]         crv = '0, cwv = '0;
  logic [1:0][NC-1:0][AW-1:0] cra = '0, cwa = '0;
  logic [1:0][NC-1:0][DW-1:0] cwd = '0;
  wire  [1:0][NC-1:0]         crr, cwr;
  wire  [1:0][NC-1:0][DW-1:0] crd;

  wire  [1:0][NCH-1:0]         mrv, mwv, mrr, mwr;
  wire  [1:0][NCH-1:0][AW-1:0] mra, mwa;
  wire  [1:0][NCH-1:0][DW-1:0] mwd, mrd;

  logic [1:0][NCH-1:0]         m_rr = '0, m_wr = '0, f_rr = '0;
  logic [1:0][NCH-1:0][DW-1:0] m_rd = '0, f_rd = '0;
  logic model_en = 1'b1;
  logic rand_lat = 1'b0;
  int   lat = 2;

  assign mrr = model_en ? m_rr : f_rr;
  assign mrd = model_en ? m_rd : f_rd;
  assign mwr = model_en ? m_wr : '0;

  logic [DW-1:0] mem [2][256];
  logic [DW-1:0] ref_mem [128];
  int rcnt [2][NCH];
  int wcnt [2][NCH];
  int rl   [2][NCH];
  int wl   [2][NCH];

  int checks = 0;
  int failures = 0;

  mem_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CONSUMERS(NC),
    .NUM_CHANNELS(NCH), .WRITE_ENABLE(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .consumer_read_valid(crv[0]), .consumer_read_addr(cra[0]),
    .consumer_read_ready(crr[0]), .consumer_read_data(crd[0]),
    .consumer_write_valid(cwv[0]), .consumer_write_addr(cwa[0]),
    .consumer_write_data(cwd[0]), .consumer_write_ready(cwr[0]),
    .mem_read_valid(mrv[0]), .mem_read_addr(mra[0]),
    .mem_read_ready(mrr[0]), .mem_read_data(mrd[0]),
    .mem_write_valid(mwv[0]), .mem_write_addr(mwa[0]),
    .mem_write_data(mwd[0]), .mem_write_ready(mwr[0])
  );

  mem_controller #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CONSUMERS(NC),
    .NUM_CHANNELS(NCH), .WRITE_ENABLE(1'b0)
  ) u_ro (
    .clk(clk), .rst_n(rst_n),
    .consumer_read_valid(crv[1]), .consumer_read_addr(cra[1]),
    .consumer_read_ready(crr[1]), .consumer_read_data(crd[1]),
    .consumer_write_valid(cwv[1]), .consumer_write_addr(cwa[1]),
    .consumer_write_data(cwd[1]), .consumer_write_ready(cwr[1]),
    .mem_read_valid(mrv[1]), .mem_read_addr(mra[1]),
    .mem_read_ready(mrr[1]), .mem_read_data(mrd[1]),
    .mem_write_valid(mwv[1]), .mem_write_addr(mwa[1]),
    .mem_write_data(mwd[1]), .mem_write_ready(mwr[1])
  );

  // Memory: answers a held request with a one-cycle ready pulse.
  always @(negedge clk) begin
    if (!rst_n || !model_en) begin
      m_rr = '0;
      m_wr = '0;
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < NCH; c++) begin
          rcnt[k][c] = 0;
          wcnt[k][c] = 0;
        end
    end else begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < NCH; c++) begin
          if (m_rr[k][c]) begin
            m_rr[k][c] = 1'b0;
            rcnt[k][c] = 0;
          end else if (mrv[k][c]) begin
            if (rcnt[k][c] == 0)
              rl[k][c] = rand_lat ? int'($urandom_range(0, 3)) : lat;
            rcnt[k][c]++;
            if (rcnt[k][c] == rl[k][c] + 1) begin
              m_rr[k][c] = 1'b1;
              m_rd[k][c] = mem[k][mra[k][c]];
            end
          end
          if (m_wr[k][c]) begin
            m_wr[k][c] = 1'b0;
            wcnt[k][c] = 0;
          end else if (mwv[k][c]) begin
            if (wcnt[k][c] == 0)
              wl[k][c] = rand_lat ? int'($urandom_range(0, 3)) : lat;
            wcnt[k][c]++;
            if (wcnt[k][c] == wl[k][c] + 1) begin
              m_wr[k][c] = 1'b1;
              mem[k][mwa[k][c]] = mwd[k][c];
            end
          end
        end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({crr, cwr, mrv, mwv} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got %h want 0", {crr, cwr, mrv, mwv});
    end
    checks++;
    if ({crd, mra, mwa, mwd} !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", {crd, mra, mwa, mwd});
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();
    checks++;
    if (mrv !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: mrv %b want 0", mrv);
    end
  endtask

  task automatic test_single_read();
    mem[0][5] = 8'h03;
    lat = 2;
    crv[0][2] = 1'b1;
    cra[0][2] = 8'h05;
    cyc();
    checks++;
    if (mrv[0] !== 4'b0001 || mra[0][0] !== 8'h05) begin
      failures++;
      $display("FAIL single_memreq: valid %b addr %h want 0001 05",
               mrv[0], mra[0][0]);
    end
    cyc();
    cyc();
    checks++;
    if (crr[0] !== '0) begin
      failures++;
      $display("FAIL single_early: ready %b want 0", crr[0]);
    end
    cyc();
    checks++;
    if (crr[0] !== 8'b0000_0100 || crd[0][2] !== 8'h03) begin
      failures++;
      $display("FAIL single_resp: ready %b data %h want 00000100 03",
               crr[0], crd[0][2]);
    end
    cyc();
    checks++;
    if (crr[0][2] !== 1'b1 || mrv[0] !== '0) begin
      failures++;
      $display("FAIL single_hold: ready %b mrv %b want 1 0",
               crr[0][2], mrv[0]);
    end
    crv[0][2] = 1'b0;
    cyc();
    checks++;
    if (crr[0] !== '0) begin
      failures++;
      $display("FAIL single_release: ready %b want 0", crr[0]);
    end
  endtask

  task automatic test_eight_reads();
    int rc [NC];
    logic [DW-1:0] got [NC];
    int lo_max, hi_min;
    lat = 2;
    for (int i = 0; i < NC; i++) begin
      mem[0][i] = DW'(i);
      cra[0][i] = AW'(i);
      rc[i] = -1;
      got[i] = 8'hxx;
    end
    crv[0] = '1;
    cyc();
    checks++;
    if (mrv[0] !== 4'hf || mra[0] !== {8'd3, 8'd2, 8'd1, 8'd0}) begin
      failures++;
      $display("FAIL eight_first_claim: valid %b addr %h want f 03020100",
               mrv[0], mra[0]);
    end
    for (int t = 1; t < 60 && crv[0] != '0; t++) begin
      for (int i = 0; i < NC; i++)
        if (crv[0][i] && crr[0][i]) begin
          rc[i] = t;
          got[i] = crd[0][i];
          crv[0][i] = 1'b0;
        end
      if (crv[0] != '0) cyc();
    end
    checks++;
    if (crv[0] !== '0) begin
      failures++;
      $display("FAIL eight_timeout: pending %b want 0", crv[0]);
      crv[0] = '0;
    end
    for (int i = 0; i < NC; i++) begin
      checks++;
      if (got[i] !== DW'(i)) begin
        failures++;
        $display("FAIL eight_data[%0d]: got %h want %h", i, got[i], DW'(i));
      end
    end
    lo_max = 0;
    hi_min = 1000;
    for (int i = 0; i < 4; i++) if (rc[i] > lo_max) lo_max = rc[i];
    for (int i = 4; i < NC; i++) if (rc[i] < hi_min) hi_min = rc[i];
    checks++;
    if (!(lo_max < hi_min)) begin
      failures++;
      $display("FAIL eight_order: low group done %0d high group first %0d",
               lo_max, hi_min);
    end
    cyc();
    cyc();
  endtask

  task automatic test_write();
    bit seen = 0;
    lat = 1;
    mem[0][8'h15] = 8'h00;
    cwv[0][5] = 1'b1;
    cwa[0][5] = 8'h15;
    cwd[0][5] = 8'h07;
    cyc();
    checks++;
    if (mwv[0] !== 4'b0001 || mwa[0][0] !== 8'h15 || mwd[0][0] !== 8'h07) begin
      failures++;
      $display("FAIL write_memreq: valid %b addr %h data %h want 0001 15 07",
               mwv[0], mwa[0][0], mwd[0][0]);
    end
    for (int t = 0; t < 10 && !seen; t++) begin
      cyc();
      if (cwr[0] == 8'b0010_0000) seen = 1;
    end
    checks++;
    if (!seen || mem[0][8'h15] !== 8'h07) begin
      failures++;
      $display("FAIL write_done: ready_seen %0d mem %h want 1 07",
               seen, mem[0][8'h15]);
    end
    cwv[0][5] = 1'b0;
    cyc();
    checks++;
    if (cwr[0] !== '0) begin
      failures++;
      $display("FAIL write_release: ready %b want 0", cwr[0]);
    end
  endtask

  task automatic test_read_then_write();
    int rt = -1, wt = -1;
    logic [DW-1:0] rdat = '0;
    lat = 1;
    mem[0][0] = 8'ha5;
    mem[0][8'h10] = 8'h00;
    crv[0][1] = 1'b1;
    cra[0][1] = 8'h00;
    cwv[0][1] = 1'b1;
    cwa[0][1] = 8'h10;
    cwd[0][1] = 8'h09;
    cyc();
    checks++;
    if (mrv[0] !== 4'b0001 || mwv[0] !== '0) begin
      failures++;
      $display("FAIL rw_read_first: mrv %b mwv %b want 0001 0000",
               mrv[0], mwv[0]);
    end
    for (int t = 1; t < 30 && (crv[0][1] || cwv[0][1]); t++) begin
      cyc();
      if (crv[0][1] && crr[0][1]) begin
        rt = t;
        rdat = crd[0][1];
        crv[0][1] = 1'b0;
      end
      if (cwv[0][1] && cwr[0][1]) begin
        wt = t;
        cwv[0][1] = 1'b0;
      end
    end
    checks++;
    if (rt < 0 || wt < 0 || !(rt < wt)) begin
      failures++;
      $display("FAIL rw_order: read at %0d write at %0d want read first",
               rt, wt);
    end
    checks++;
    if (rdat !== 8'ha5 || mem[0][8'h10] !== 8'h09) begin
      failures++;
      $display("FAIL rw_data: read %h mem %h want a5 09",
               rdat, mem[0][8'h10]);
    end
    crv[0] = '0;
    cwv[0] = '0;
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid();
    bit bad = 0;
    model_en = 1'b0;
    crv[0][0] = 1'b1;
    cra[0][0] = 8'h33;
    cyc();
    checks++;
    if (mrv[0] !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_setup: mrv %b want 0001", mrv[0]);
    end
    cyc();
    rst_n = 1'b0;
    crv[0] = '0;
    #1;
    checks++;
    if ({crr[0], cwr[0], mrv[0], mwv[0], crd[0], mra[0]} !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got %h want 0",
               {crr[0], cwr[0], mrv[0], mwv[0], crd[0], mra[0]});
    end
    cyc();
    rst_n = 1'b1;
    f_rr[0][0] = 1'b1;
    f_rd[0][0] = 8'h77;
    for (int t = 0; t < 4; t++) begin
      cyc();
      if (t == 1) f_rr[0][0] = 1'b0;
      if (crr[0] != '0 || mrv[0] != '0) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL midrst_late_ready: spurious response %b mrv %b",
               crr[0], mrv[0]);
    end
    f_rr = '0;
    model_en = 1'b1;
    cyc();
  endtask

  task automatic test_read_only();
    bit wseen = 0, rdone = 0;
    logic [DW-1:0] rdat = '0;
    lat = 1;
    mem[1][4] = 8'h44;
    mem[1][8'h20] = 8'h11;
    cwv[1][0] = 1'b1;
    cwa[1][0] = 8'h20;
    cwd[1][0] = 8'h55;
    crv[1][3] = 1'b1;
    cra[1][3] = 8'h04;
    for (int t = 0; t < 20; t++) begin
      cyc();
      if (mwv[1] != '0 || cwr[1] != '0 || mwa[1] != '0 || mwd[1] != '0)
        wseen = 1;
      if (crv[1][3] && crr[1][3]) begin
        rdone = 1;
        rdat = crd[1][3];
        crv[1][3] = 1'b0;
      end
    end
    checks++;
    if (wseen || mem[1][8'h20] !== 8'h11) begin
      failures++;
      $display("FAIL ro_write_ignored: write activity %0d mem %h want 0 11",
               wseen, mem[1][8'h20]);
    end
    checks++;
    if (!rdone || rdat !== 8'h44) begin
      failures++;
      $display("FAIL ro_read: done %0d data %h want 1 44", rdone, rdat);
    end
    cwv[1] = '0;
    crv[1] = '0;
    cyc();
  endtask

  task automatic test_random();
    logic [NC-1:0] rm, wm;
    int spurious;
    rand_lat = 1'b1;
    for (int a = 0; a < 128; a++) begin
      ref_mem[a] = DW'($urandom);
      mem[0][a] = ref_mem[a];
    end
    for (int r = 0; r < 12; r++) begin
      rm = NC'($urandom);
      wm = NC'($urandom);
      spurious = 0;
      for (int i = 0; i < NC; i++) begin
        if (rm[i]) begin
          crv[0][i] = 1'b1;
          cra[0][i] = AW'($urandom_range(0, 127));
        end
        if (wm[i]) begin
          cwv[0][i] = 1'b1;
          cwa[0][i] = AW'(128 + r * 8 + i);
          cwd[0][i] = DW'($urandom);
        end
      end
      for (int t = 0; t < 300 && (crv[0] | cwv[0]) != '0; t++) begin
        cyc();
        if ((crr[0] & ~crv[0]) != '0 || (cwr[0] & ~cwv[0]) != '0)
          spurious++;
        for (int i = 0; i < NC; i++) begin
          if (crv[0][i] && crr[0][i]) begin
            checks++;
            if (crd[0][i] !== ref_mem[cra[0][i][6:0]]) begin
              failures++;
              $display("FAIL rand_read r%0d c%0d: got %h want %h",
                       r, i, crd[0][i], ref_mem[cra[0][i][6:0]]);
            end
            crv[0][i] = 1'b0;
          end
          if (cwv[0][i] && cwr[0][i]) cwv[0][i] = 1'b0;
        end
      end
      checks++;
      if ((crv[0] | cwv[0]) != '0 || spurious != 0) begin
        failures++;
        $display("FAIL rand_round r%0d: pending %b spurious %0d want 0 0",
                 r, crv[0] | cwv[0], spurious);
      end
      crv[0] = '0;
      cwv[0] = '0;
      cyc();
      cyc();
      for (int i = 0; i < NC; i++)
        if (wm[i]) begin
          checks++;
          if (mem[0][cwa[0][i]] !== cwd[0][i]) begin
            failures++;
            $display("FAIL rand_write r%0d c%0d: mem %h want %h",
                     r, i, mem[0][cwa[0][i]], cwd[0][i]);
          end
        end
    end
    rand_lat = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) mem[k][a] = '0;
    test_reset();
    test_single_read();
    test_eight_reads();
    test_write();
    test_read_then_write();
    test_reset_mid();
    test_read_only();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
